// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared types and default widths for the counter subsystem.
//   ovf_state_t     : overflow-handling sequencer states
//   CNT_WIDTH_DEF   : default width of the monitored counter value
//   EPOCH_WIDTH_DEF : default width of the epoch (overflow event) counter
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    REPORT = 2'd2,
    REINIT = 2'd3
  } ovf_state_t;

  localparam int CNT_WIDTH_DEF   = 8;
  localparam int EPOCH_WIDTH_DEF = 16;

endpackage

// File: rtl/counter_overflow_ctrl.sv
// counter_overflow_ctrl
//   Closes the overflow loop of the counter: acknowledges each overflow,
//   numbers it as an epoch, hands an event record to a consumer over
//   valid/ready and optionally restarts the counter after a programmable
//   number of epochs.
//
//   clk              : system clock, rising edge
//   res_n            : asynchronous active-low reset
//   arm              : enables overflow handling (sampled in IDLE only)
//   reinit_threshold : epoch count that triggers reinit, 0 = never
//   overflow         : sticky overflow flag from counter
//   value            : current counter value
//   clear_overflow   : overflow acknowledge to counter
//   reinit           : one-cycle restart pulse to counter
//   evt_valid        : event record valid
//   evt_ready        : consumer accepts the record
//   evt_epoch        : 1-based epoch number of the record
//   evt_value        : counter value captured at detection
//   epoch_count      : live epoch counter
//   busy             : high in any state other than IDLE
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for an armed overflow
//   CLEAR  | acknowledging, holding clear_overflow until overflow drops
//   REPORT | presenting the event record until the handshake
//   REINIT | one-cycle restart pulse, epoch counter cleared
module counter_overflow_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH       = CNT_WIDTH_DEF,
  parameter int EPOCH_WIDTH = EPOCH_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic                   arm,
  input  logic [EPOCH_WIDTH-1:0] reinit_threshold,
  input  logic                   overflow,
  input  logic [WIDTH-1:0]       value,
  output logic                   clear_overflow,
  output logic                   reinit,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [EPOCH_WIDTH-1:0] evt_epoch,
  output logic [WIDTH-1:0]       evt_value,
  output logic [EPOCH_WIDTH-1:0] epoch_count,
  output logic                   busy
);

  ovf_state_t state, state_nxt;

  logic                   detect;
  logic                   handshake;
  logic                   thr_hit;
  logic [EPOCH_WIDTH-1:0] epoch_inc;

  assign detect    = (state == IDLE) && arm && overflow;
  // evt_valid is high exactly while in REPORT, so it doubles as the state qualifier
  assign handshake = evt_valid && evt_ready;
  assign thr_hit   = (reinit_threshold != '0) && (epoch_count == reinit_threshold);
  // natural modulo-2^EPOCH_WIDTH wrap; a record with epoch 0 is legal
  assign epoch_inc = epoch_count + EPOCH_WIDTH'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (detect) state_nxt = CLEAR;
      end
      CLEAR: begin
        if (!overflow) state_nxt = REPORT;
      end
      REPORT: begin
        if (handshake) state_nxt = thr_hit ? REINIT : IDLE;
      end
      REINIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each one
  // changes on the same edge as the state and no input reaches an output
  // combinationally.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state          <= IDLE;
      clear_overflow <= 1'b0;
      reinit         <= 1'b0;
      evt_valid      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      clear_overflow <= (state_nxt == CLEAR);
      reinit         <= (state_nxt == REINIT);
      evt_valid      <= (state_nxt == REPORT);
      busy           <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      epoch_count <= '0;
      evt_epoch   <= '0;
      evt_value   <= '0;
    end else begin
      if (detect) begin
        epoch_count <= epoch_inc;
        evt_epoch   <= epoch_inc;
        evt_value   <= value;
      end else if (state == REINIT) begin
        epoch_count <= '0;
      end
    end
  end

endmodule
